// File: rtl/line_fetch_scheduler.sv
// line_fetch_scheduler
//   Refills the video line buffer from the PSRAM framebuffer on every
//   line_request. It also shares the single PSRAM command port with a
//   one-word host write path; line fetches always have priority.
//   Everything runs in the clk_psram domain.
//
// Ports
//   clk_psram, rst            clock, synchronous active-high reset
//   frame_start, line_request one-cycle pulses from the video timing side
//   mem_cmd_*                 PSRAM command port (valid/ready)
//   mem_wdata                 write data for host writes, {8'h00, pixel}
//   mem_rd_valid/data         read beats returned by the PSRAM controller
//   wr_addr/wr_data/wr_en     line buffer write port (one strobe per beat)
//   host_wr_*                 single-word host write port (valid/ready)
//   busy                      FSM is not idle
//   overrun_count             saturating count of requests seen while busy
//
// Handshakes: a command transfers on the rising edge where valid and ready
// are both 1. mem_cmd_valid, once raised, stays high with stable
// addr/len/we/wdata until that edge. host_wr_ready is high only in the
// cycle the host word is taken.
//
// Build option: define LINE_DOUBLE_EN to fetch every source line twice
// (2x vertical scale); only V_RES/2 source lines are then valid.
module line_fetch_scheduler #(
  parameter int H_RES = 800,
  parameter int V_RES = 480,
  parameter int BURST_LEN = 16,
  parameter int ADDR_W = 22,
  parameter logic [ADDR_W-1:0] FB_BASE = '0
) (
  input  logic              clk_psram,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              line_request,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [7:0]        mem_cmd_len,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rd_valid,
  input  logic [31:0]       mem_rd_data,
  output logic [9:0]        wr_addr,
  output logic [23:0]       wr_data,
  output logic              wr_en,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [23:0]       host_wr_data,
  output logic              busy,
  output logic [7:0]        overrun_count
);

  localparam int IDX_W  = $clog2(V_RES + 1);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
`ifdef LINE_DOUBLE_EN
  localparam logic [IDX_W-1:0] LINES = IDX_W'(V_RES / 2);
`else
  localparam logic [IDX_W-1:0] LINES = IDX_W'(V_RES);
`endif

  typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_CMD} state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    line_idx, idx_eff, nxt_idx;
  logic [ADDR_W-1:0]   line_base, base_eff, nxt_base, burst_addr;
  logic [ADDR_W-1:0]   host_addr_q;
  logic [23:0]         host_data_q;
  logic [9:0]          px;
  logic [BEAT_W-1:0]   beat;
  logic                pending, stale, phase;
  logic                beat_ok, last_beat, line_end, abandon, line_finish;
  logic                adv, restart_ok, start_fetch, host_take;
  logic                unused_ok;

  // Upper byte of each read word carries no pixel data.
  assign unused_ok = &{1'b0, mem_rd_data[31:24]};

  // frame_start applies before anything else in the same cycle.
  assign idx_eff  = frame_start ? '0 : line_idx;
  assign base_eff = frame_start ? FB_BASE : line_base;

  assign beat_ok     = (state == RD_DATA) && mem_rd_valid;
  assign last_beat   = beat_ok && (beat == BEAT_W'(BURST_LEN - 1));
  assign line_end    = (px == 10'(H_RES - 1));
  assign abandon     = pending || line_request;
  assign line_finish = last_beat && (line_end || abandon);

  // A fetch that started before a frame_start is "stale": finishing it must
  // not move the line pointer off line 0.
  always_comb begin
    adv = 1'b0;
    if (line_finish && !frame_start && !stale) begin
`ifdef LINE_DOUBLE_EN
      adv = line_end ? phase : 1'b1;
`else
      adv = 1'b1;
`endif
    end
  end

  assign nxt_idx    = adv ? idx_eff + 1'b1 : idx_eff;
  assign nxt_base   = adv ? base_eff + ADDR_W'(H_RES) : base_eff;
  assign restart_ok = abandon && (nxt_idx < LINES);

  always_comb begin
    state_n     = state;
    start_fetch = 1'b0;
    host_take   = 1'b0;
    case (state)
      IDLE: begin
        if ((line_request || pending) && (idx_eff < LINES)) begin
          start_fetch = 1'b1;
          state_n     = RD_CMD;
        end else if (host_wr_valid) begin
          host_take = 1'b1;
          state_n   = WR_CMD;
        end
      end
      RD_CMD:  if (mem_cmd_ready) state_n = RD_DATA;
      RD_DATA: begin
        if (line_finish)    state_n = restart_ok ? RD_CMD : IDLE;
        else if (last_beat) state_n = RD_CMD;
      end
      WR_CMD:  if (mem_cmd_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_psram) begin
    if (rst) begin
      state         <= IDLE;
      line_idx      <= '0;
      line_base     <= FB_BASE;
      burst_addr    <= '0;
      host_addr_q   <= '0;
      host_data_q   <= '0;
      px            <= '0;
      beat          <= '0;
      pending       <= 1'b0;
      stale         <= 1'b0;
      phase         <= 1'b0;
      overrun_count <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
    end else begin
      state <= state_n;
      wr_en <= beat_ok;
      if (beat_ok) begin
        wr_addr <= px;
        wr_data <= mem_rd_data[23:0];
        px      <= px + 1'b1;
        beat    <= beat + 1'b1;
      end
      if (state == RD_CMD && mem_cmd_ready) beat <= '0;
      if (start_fetch) begin
        burst_addr <= base_eff;
        px         <= '0;
      end
      if (line_finish) begin
        if (restart_ok) begin
          burst_addr <= nxt_base;
          px         <= '0;
        end
      end else if (last_beat) begin
        burst_addr <= burst_addr + ADDR_W'(BURST_LEN);
      end
      if (line_finish) begin
        line_idx  <= nxt_idx;
        line_base <= nxt_base;
      end else if (frame_start) begin
        line_idx  <= '0;
        line_base <= FB_BASE;
      end
`ifdef LINE_DOUBLE_EN
      if (frame_start) phase <= 1'b0;
      else if (line_finish && !stale) phase <= line_end ? ~phase : 1'b0;
`endif
      if (state == IDLE || line_finish) pending <= 1'b0;
      else if (line_request)            pending <= 1'b1;
      if (frame_start && (state == RD_CMD || state == RD_DATA) && !line_finish)
        stale <= 1'b1;
      else if (start_fetch || line_finish)
        stale <= 1'b0;
      if (line_request && state != IDLE && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 1'b1;
      if (host_take) begin
        host_addr_q <= host_wr_addr;
        host_data_q <= host_wr_data;
      end
    end
  end

  always_comb begin
    mem_cmd_valid = (state == RD_CMD) || (state == WR_CMD);
    mem_cmd_we    = (state == WR_CMD);
    mem_cmd_addr  = '0;
    mem_cmd_len   = '0;
    mem_wdata     = '0;
    if (state == RD_CMD) begin
      mem_cmd_addr = burst_addr;
      mem_cmd_len  = 8'(BURST_LEN);
    end else if (state == WR_CMD) begin
      mem_cmd_addr = host_addr_q;
      mem_cmd_len  = 8'd1;
      mem_wdata    = {8'h00, host_data_q};
    end
  end

  assign host_wr_ready = host_take && !rst;
  assign busy          = (state != IDLE);

endmodule
